// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor pixel stage.
// Palette, background colour and the per-pixel metadata bundle.
package sprite_pkg;

  localparam int PIX_W = 9;

  typedef logic [23:0] rgb_t;
  typedef logic [0:15][23:0] palette_t;
  typedef logic [1:0] layer_id_t;

  // Slot 0 is the transparency key; its colour never reaches the screen.
  localparam palette_t PALETTE = '{
    24'h200020, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  localparam rgb_t BG_COLOR = 24'h000000;

  typedef struct packed {
    logic             valid;
    logic             hit;
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
  } pix_meta_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Shared sprite-ROM read port: bank/address out, palette index back.
// master = compositor, slave = ROM.
interface sprite_compositor_if #(
  parameter int ADDR_W = 18,
  parameter int IDX_W  = 4,
  parameter int BANK_W = 2
);
  logic [BANK_W-1:0] rom_bank;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_data;

  modport master (
    output rom_bank,
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_bank,
    input  rom_addr,
    output rom_data
  );
endinterface

// File: rtl/sprite_prio_enc.sv
// Priority encoder: lowest set bit wins, plus any-hit flag.
// Purely combinational, width set by N.
module sprite_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     hits,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hits[i]) idx = IDX_W'(i);
    end
  end

  assign any = |hits;

endmodule

// File: rtl/sprite_compositor.sv
// Layer select, sprite-ROM read, transparency and palette to RGB.
// Optional layer-0 blinking with `define SPRITE_BLINK_EN.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int ADDR_W       = 18,
  parameter int IDX_W        = 4,
  parameter int ROM_LAT      = 2,
  parameter int TRANSP_IDX   = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         pix_valid,
  input  logic [8:0]                   PixelX,
  input  logic [8:0]                   PixelY,
  input  logic                         frame_start,
  input  logic [NUM_LAYERS-1:0]        layer_hit,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  sprite_compositor_if.master          rom,
  output logic                         out_valid,
  output logic [8:0]                   out_x,
  output logic [8:0]                   out_y,
  output logic [7:0]                   Red,
  output logic [7:0]                   Green,
  output logic [7:0]                   Blue
);

  localparam int BANK_W =
    (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0] hit_mask;
  logic [NUM_LAYERS-1:0] hits;
  logic [BANK_W-1:0]     win;
  logic                  any_hit;
  logic [BANK_W-1:0]     bank_q;
  logic [ADDR_W-1:0]     addr_q;
  pix_meta_t             s0;
  pix_meta_t             dly [ROM_LAT];
  pix_meta_t             tail;
  rgb_t                  rgb_q;

`ifdef SPRITE_BLINK_EN
  localparam int CNT_W =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt;
  logic             blink_on;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    hit_mask    = '1;
    hit_mask[0] = blink_on;
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign hit_mask = '1;
`endif

  assign hits = layer_hit & hit_mask;

  sprite_prio_enc #(
    .N     (NUM_LAYERS),
    .IDX_W (BANK_W)
  ) u_enc (
    .hits (hits),
    .idx  (win),
    .any  (any_hit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s0     <= '0;
      bank_q <= '0;
      addr_q <= '0;
    end else begin
      s0.valid <= pix_valid;
      s0.hit   <= any_hit;
      s0.x     <= PixelX;
      s0.y     <= PixelY;
      bank_q   <= any_hit ? win : '0;
      addr_q   <= any_hit ?
                  layer_addr[win*ADDR_W +: ADDR_W] : '0;
    end
  end

  assign rom.rom_bank = bank_q;
  assign rom.rom_addr = addr_q;

  // Metadata rides alongside the ROM read so it meets rom_data.
  for (genvar k = 0; k < ROM_LAT; k++) begin : g_dly
    if (k == 0) begin : g_head
      always_ff @(posedge Clk) begin
        if (Reset) dly[k] <= '0;
        else       dly[k] <= s0;
      end
    end else begin : g_body
      always_ff @(posedge Clk) begin
        if (Reset) dly[k] <= '0;
        else       dly[k] <= dly[k-1];
      end
    end
  end

  assign tail = dly[ROM_LAT-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      rgb_q     <= '0;
    end else begin
      out_valid <= tail.valid;
      out_x     <= tail.x;
      out_y     <= tail.y;
      if (!tail.valid)
        rgb_q <= '0;
      else if (tail.hit &&
               rom.rom_data != IDX_W'(TRANSP_IDX))
        rgb_q <= PALETTE[rom.rom_data];
      else
        rgb_q <= BG_COLOR;
    end
  end

  assign {Red, Green, Blue} = rgb_q;

endmodule
